// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO edge-interrupt block: input sync, edge detect, sticky pending, mask, level irq.
// Define GPIO_IRQ_DEBOUNCE_EN to insert a per-bit debounce filter after the synchroniser.
module wb_gpio_irq #(
    parameter int gpio_io_width = 8,
    parameter int wb_dat_width  = 32,
    parameter int wb_adr_width  = 32,
    parameter int debounce_div  = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [wb_adr_width-1:0]  wb_adr_i,
    input  logic [wb_dat_width-1:0]  wb_dat_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [wb_dat_width-1:0]  wb_dat_o,
    input  logic [gpio_io_width-1:0] gpio_i,
    output logic                     irq
);
    localparam int W = gpio_io_width;

    logic [W-1:0]            sync_p0, sync_p1, prev_p2, level;
    logic [W-1:0]            pending, mask, rise_en, fall_en;
    logic [W-1:0]            rise, fall, clr;
    logic                    ack_q, req, commit;
    logic [1:0]              sel;
    logic [wb_dat_width-1:0] rd_data;
    logic                    unused_bits;

    assign req      = wb_cyc_i & wb_stb_i;
    assign commit   = req & ~ack_q;
    assign sel      = wb_adr_i[3:2];
    assign wb_ack_o = req & ack_q;

    // Stage p0/p1: two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= gpio_i;
            sync_p1 <= sync_p0;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int PW = (debounce_div > 1) ? $clog2(debounce_div) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [W-1:0]  filt;
    logic [1:0]    cnt [W];

    assign tick  = (presc == PW'(debounce_div - 1));
    assign level = filt;
    assign unused_bits = ^{wb_adr_i, wb_dat_i};

    // Filtered level only flips after three consecutive disagreeing sample ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            filt  <= '0;
            for (int i = 0; i < W; i++) cnt[i] <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                for (int i = 0; i < W; i++) begin
                    if (sync_p1[i] != filt[i]) begin
                        if (cnt[i] == 2'd2) begin
                            filt[i] <= ~filt[i];
                            cnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end else begin
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end
`else
    assign level = sync_p1;
    assign unused_bits = ^{wb_adr_i, wb_dat_i, 32'(debounce_div)};
`endif

    assign rise = level & ~prev_p2 & rise_en;
    assign fall = ~level & prev_p2 & fall_en;
    assign clr  = (commit && wb_we_i && sel == 2'd1) ? wb_dat_i[W-1:0] : '0;

    always_comb begin
        rd_data = '0;
        case (sel)
            2'd0: rd_data[W-1:0] = level;
            2'd1: rd_data[W-1:0] = pending;
            2'd2: rd_data[W-1:0] = mask;
            default: begin
                rd_data[W-1:0]  = rise_en;
                rd_data[16 +: W] = fall_en;
            end
        endcase
    end

    // Stage p2: edge history, sticky pending (set beats clear), registers and irq
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_p2  <= '0;
            pending  <= '0;
            mask     <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            ack_q    <= 1'b0;
            wb_dat_o <= '0;
            irq      <= 1'b0;
        end else begin
            prev_p2 <= level;
            pending <= (pending & ~clr) | rise | fall;
            irq     <= |(pending & mask);
            ack_q   <= commit;
            if (commit && wb_we_i) begin
                case (sel)
                    2'd2: mask <= wb_dat_i[W-1:0];
                    2'd3: begin
                        rise_en <= wb_dat_i[W-1:0];
                        fall_en <= wb_dat_i[16 +: W];
                    end
                    default: ;
                endcase
            end
            if (commit && !wb_we_i) wb_dat_o <= rd_data;
        end
    end
endmodule

// File: tb/tb_wb_gpio_irq.sv
// Bench for wb_gpio_irq: directed scenarios plus random bus/pin traffic against a sample-history model.
module tb_wb_gpio_irq;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat_i, dat_o;
    logic        we, cyc, stb, ack, irq;
    logic [7:0]  gpio;

    int n_vec = 0;
    int n_err = 0;

    wb_gpio_irq #(.gpio_io_width(8), .wb_dat_width(32), .wb_adr_width(32), .debounce_div(4)) dut (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_we_i(we),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_dat_o(dat_o),
        .gpio_i(gpio), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference state: pin level sampled at each absolute clock edge, plus register contents
    logic [7:0]  lv [64];
    int          cyc_n = 0;
    int          base  = 0;
    logic [7:0]  m_pend, m_mask, m_rise, m_fall;
    logic        m_irq, m_ackq;
    logic [31:0] m_rdat;

    function automatic logic [7:0] lvl(input int e);
        return (e < base) ? 8'h00 : lv[e & 63];
    endfunction

    function automatic logic [31:0] mread(input logic [1:0] a, input logic [7:0] status);
        case (a)
            2'd0:    return {24'h0, status};
            2'd1:    return {24'h0, m_pend};
            2'd2:    return {24'h0, m_mask};
            default: return {8'h0, m_fall, 8'h0, m_rise};
        endcase
    endfunction

    task automatic m_clear();
        m_pend = '0; m_mask = '0; m_rise = '0; m_fall = '0;
        m_irq = 1'b0; m_ackq = 1'b0; m_rdat = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] s2, pv, ev, clr;
        logic       commit, irq_n;
        @(posedge clk);
        cyc_n++;
        lv[cyc_n & 63] = gpio;
        if (rst) begin
            // A pin seen at edge e is visible as a level two edges later, and its predecessor one before that
            s2     = lvl(cyc_n - 2);
            pv     = lvl(cyc_n - 3);
            ev     = (s2 & ~pv & m_rise) | (~s2 & pv & m_fall);
            irq_n  = |(m_pend & m_mask);
            commit = cyc & stb & ~m_ackq;
            clr    = 8'h00;
            if (commit && we) begin
                case (adr[3:2])
                    2'd1: clr = dat_i[7:0];
                    2'd2: m_mask = dat_i[7:0];
                    2'd3: begin m_rise = dat_i[7:0]; m_fall = dat_i[23:16]; end
                    default: ;
                endcase
            end else if (commit) begin
                m_rdat = mread(adr[3:2], s2);
            end
            m_pend = (m_pend & ~clr) | ev;
            m_irq  = irq_n;
            m_ackq = commit;
        end
        #1;
        chk("irq", 32'(irq), 32'(m_irq));
        chk("ack", 32'(ack), 32'(cyc & stb & m_ackq));
        chk("dat_o", dat_o, m_rdat);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
        adr = a; dat_i = d; we = w; cyc = 1'b1; stb = 1'b1;
        tick();
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus(1'b0, a, 32'h0);
        d = dat_o;
    endtask

    initial begin
        logic [31:0] d;
        int          r;
        rst = 1'b0; adr = '0; dat_i = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; gpio = 8'h00;
        m_clear();
        idle(3);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_dat", dat_o, 32'h0);
        rst = 1'b1; base = cyc_n + 1;
        for (int a = 0; a < 4; a++) begin
            rd(32'(a * 4), d);
            chk("reset_reg", d, 32'h0);
        end

        // Rising edge on bit 0: latency to pending and irq, then W1C
        bus(1'b1, 32'hC, 32'h0000_0001);
        bus(1'b1, 32'h8, 32'h0000_0001);
        gpio = 8'h01;
        tick(); chk("rise_k",   32'(irq), 32'h0);
        tick(); chk("rise_k1",  32'(irq), 32'h0);
        tick(); chk("rise_k2",  32'(irq), 32'h0);
        tick(); chk("rise_k3",  32'(irq), 32'h1);
        rd(32'h4, d); chk("rise_pend", d, 32'h0000_0001);
        bus(1'b1, 32'h4, 32'h0000_0001);
        chk("rise_clr_irq", 32'(irq), 32'h0);
        rd(32'h4, d); chk("rise_pend_clr", d, 32'h0);

        // Falling edge on bit 7 while masked, then unmask
        gpio = 8'h81;
        idle(4);
        bus(1'b1, 32'hC, 32'h0080_0000);
        bus(1'b1, 32'h8, 32'h0000_0000);
        bus(1'b1, 32'h4, 32'h0000_00FF);
        gpio = 8'h01;
        idle(4);
        rd(32'h4, d); chk("fall_pend", d, 32'h0000_0080);
        chk("fall_masked_irq", 32'(irq), 32'h0);
        bus(1'b1, 32'h8, 32'h0000_0080);
        chk("fall_unmask_irq", 32'(irq), 32'h1);

        // New rising edge on bit 3 lands on the same edge as its W1C
        bus(1'b1, 32'h4, 32'h0000_00FF);
        bus(1'b1, 32'hC, 32'h0000_0008);
        bus(1'b1, 32'h8, 32'h0000_0008);
        gpio = 8'h09;
        idle(4);
        chk("setwin_pre_irq", 32'(irq), 32'h1);
        gpio = 8'h01;
        idle(3);
        gpio = 8'h09;
        tick();
        tick();
        bus(1'b1, 32'h4, 32'h0000_0008);
        rd(32'h4, d); chk("setwin_pend", d, 32'h0000_0008);
        chk("setwin_irq", 32'(irq), 32'h1);

        // Back-to-back STATUS reads, write to STATUS ignored, decode ignores other address bits
        bus(1'b1, 32'h4, 32'h0000_00FF);
        bus(1'b1, 32'h8, 32'h0000_0000);
        gpio = 8'hA5;
        idle(4);
        adr = 32'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("b2b_ack_hi", 32'(ack), 32'h1); chk("b2b_dat", dat_o, 32'h0000_00A5);
            tick(); chk("b2b_ack_lo", 32'(ack), 32'h0);
        end
        cyc = 1'b0; stb = 1'b0;
        bus(1'b1, 32'h0, 32'hFFFF_FFFF);
        rd(32'h0, d);         chk("status_ro", d, 32'h0000_00A5);
        rd(32'h1230_0003, d); chk("decode_alias", d, 32'h0000_00A5);
        rd(32'hC, d);         chk("edge_rb", d, 32'h0000_0008);

        // Random pin and bus traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) gpio = 8'($urandom);
            else if (r < 5) idle(int'($urandom_range(1, 3)));
            else bus(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
        end

        // Asynchronous reset in the middle of an acknowledged read
        bus(1'b1, 32'hC, 32'h00FF_00FF);
        bus(1'b1, 32'h8, 32'h0000_00FF);
        gpio = ~gpio;
        idle(4);
        chk("mid_pre_irq", 32'(irq), 32'h1);
        adr = 32'h8; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        tick();
        chk("mid_pre_ack", 32'(ack), 32'h1);
        chk("mid_pre_dat", dat_o, 32'h0000_00FF);
        #2 rst = 1'b0;
        #1;
        m_clear();
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_dat", dat_o, 32'h0);
        idle(2);
        cyc = 1'b0; stb = 1'b0; gpio = 8'h00;
        rst = 1'b1; base = cyc_n + 1;
        for (int a = 0; a < 4; a++) begin
            rd(32'(a * 4), d);
            chk("post_rst_reg", d, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
